// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel type, pattern encodings and colour-bar table.
package vga_pkg;

    typedef logic [2:0][3:0] pixel_t;

    typedef enum logic [1:0] {
        PAT_BARS    = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_RAMP    = 2'd2,
        PAT_SOLID   = 2'd3
    } pattern_e;

    localparam pixel_t BAR_TABLE [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

endpackage

// File: rtl/vga_pattern_lut.sv
// Combinational colour mapping from pixel coordinates and pattern select.
module vga_pattern_lut
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  pattern_e      pattern,
    input  pixel_t        solid_rgb,
    output pixel_t        pixel
);

    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int BAND_W = H_ACTIVE / 16;

    logic [2:0] bar;
    logic [3:0] band;
    logic       chk;

    assign bar  = 3'(32'(x) / BAR_W);
    assign band = 4'(32'(x) / BAND_W);
    // 16x16 squares: parity of bit 4 of each coordinate
    assign chk  = 1'((32'(x) >> 4) ^ (32'(y) >> 4));

    always_comb begin
        pixel = '0;
        unique case (pattern)
            PAT_BARS:    pixel = BAR_TABLE[bar];
            PAT_CHECKER: pixel = chk ? 12'h000 : 12'hFFF;
            PAT_RAMP:    pixel = {3{band}};
            PAT_SOLID:   pixel = solid_rgb;
            default:     pixel = '0;
        endcase
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern frame source with AXI-Stream output, frame-aligned start/stop.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       enable,
    input  logic [1:0] pattern,
    input  pixel_t     solid_rgb,
    output logic       pix_tvalid,
    input  logic       pix_tready,
    output pixel_t     pix_tdata,
    output logic       pix_tlast,
    output logic       pix_tuser,
    output logic [7:0] frame_cnt
);

    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    typedef enum logic {IDLE, RUN} state_e;

    state_e    state_q, state_d;
    logic [XW-1:0] x_q, nx;
    logic [YW-1:0] y_q, ny;
    pattern_e  pat_q, pat_sel;
    pixel_t    solid_q, solid_sel, lut_pix;
    logic      load, start, frame_done;
    logic      xfer, last_x, last_y;

    assign xfer   = pix_tvalid & pix_tready;
    assign last_x = (x_q == XW'(H_ACTIVE - 1));
    assign last_y = (y_q == YW'(V_ACTIVE - 1));

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        start      = 1'b0;
        frame_done = 1'b0;
        nx         = x_q;
        ny         = y_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                    load    = 1'b1;
                    start   = 1'b1;
                    nx      = '0;
                    ny      = '0;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (last_x && last_y) begin
                        frame_done = 1'b1;
                        nx         = '0;
                        ny         = '0;
                        if (enable) begin
                            load  = 1'b1;
                            start = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        load = 1'b1;
                        nx   = last_x ? '0 : x_q + 1'b1;
                        ny   = last_x ? y_q + 1'b1 : y_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pattern inputs only matter when a frame's first pixel is loaded
    assign pat_sel   = start ? pattern_e'(pattern) : pat_q;
    assign solid_sel = start ? solid_rgb : solid_q;

    vga_pattern_lut #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (XW),
        .YW       (YW)
    ) u_lut (
        .x         (nx),
        .y         (ny),
        .pattern   (pat_sel),
        .solid_rgb (solid_sel),
        .pixel     (lut_pix)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            pat_q      <= PAT_BARS;
            solid_q    <= '0;
            pix_tvalid <= 1'b0;
            pix_tdata  <= '0;
            pix_tlast  <= 1'b0;
            pix_tuser  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= nx;
            y_q        <= ny;
            pix_tvalid <= (state_d == RUN);
            if (start) begin
                pat_q   <= pat_sel;
                solid_q <= solid_sel;
            end
            if (load) begin
                pix_tdata <= lut_pix;
                pix_tlast <= (nx == XW'(H_ACTIVE - 1));
                pix_tuser <= start;
            end else if (state_d == IDLE) begin
                pix_tdata <= '0;
                pix_tlast <= 1'b0;
                pix_tuser <= 1'b0;
            end
            if (frame_done) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
